// File: rtl/raster_pkg.sv
// Shared constants and types for the rasterizer back end: framebuffer geometry,
// write-request struct and the fragment writer state encoding.
package raster_pkg;

    localparam int CORD_WIDTH  = 10;
    localparam int ADDR_WIDTH  = 20;
    localparam int COLOR_WIDTH = 16;
    localparam int FB_WIDTH    = 640;
    localparam int FB_HEIGHT   = 480;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [COLOR_WIDTH-1:0] data;
    } fb_wr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } fw_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frag_fifo.sv
// Show-ahead write buffer for framebuffer writes. Head entry is visible on
// o_dout whenever o_empty is low; a push into a full FIFO survives only if a pop happens too.
module frag_fifo
    import raster_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_push,
    input  fb_wr_t i_din,
    input  logic   i_pop,
    output fb_wr_t o_dout,
    output logic   o_full,
    output logic   o_empty
);

    localparam int AW = $clog2(DEPTH);

    fb_wr_t      r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_pop;
    logic        w_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fragment_writer.sv
// Rasterizer fragment sink: clips fragments, forms linear framebuffer addresses,
// buffers them and issues flat-colour writes, pulsing o_done once fully drained.
module fragment_writer #(
    parameter int CORD_WIDTH  = raster_pkg::CORD_WIDTH,
    parameter int ADDR_WIDTH  = raster_pkg::ADDR_WIDTH,
    parameter int COLOR_WIDTH = raster_pkg::COLOR_WIDTH,
    parameter int FB_WIDTH    = raster_pkg::FB_WIDTH,
    parameter int FB_HEIGHT   = raster_pkg::FB_HEIGHT,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [COLOR_WIDTH-1:0]       i_color,
    input  logic [ADDR_WIDTH-1:0]        i_fb_base,
    input  logic                         i_frag_valid,
    input  logic signed [CORD_WIDTH-1:0] i_frag_x,
    input  logic signed [CORD_WIDTH-1:0] i_frag_y,
    input  logic                         i_raster_done,
    output logic                         o_mem_wr_valid,
    input  logic                         i_mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]        o_mem_wr_addr,
    output logic [COLOR_WIDTH-1:0]       o_mem_wr_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_overflow,
    output logic [15:0]                  o_clip_count
);

    import raster_pkg::*;

    fw_state_t              r_state;
    fw_state_t              w_state_nxt;
    logic                   r_armed;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [COLOR_WIDTH-1:0] r_color;
    logic                   r_s1_valid;
    logic [ADDR_WIDTH-1:0]  r_s1_addr;
    logic                   r_overflow;
    logic [15:0]            r_clip_count;

    logic                   w_start;
    logic                   w_accept;
    logic                   w_clip;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_drained;
    fb_wr_t                 w_fifo_din;
    fb_wr_t                 w_fifo_dout;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (r_armed && i_raster_done) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = IDLE;
                    o_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The rasterizer still reports done in the start cycle; only a later
    // done after it has been seen low ends the triangle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_base  <= '0;
            r_color <= '0;
        end else if (w_start) begin
            r_armed <= 1'b0;
            r_base  <= i_fb_base;
            r_color <= i_color;
        end else if (r_state == ACTIVE && !i_raster_done) begin
            r_armed <= 1'b1;
        end
    end

    // ---------------- stage 1: clip and address ----------------
    assign w_accept = i_frag_valid && (r_state == ACTIVE);
    assign w_clip   = (int'(i_frag_x) < 0) || (int'(i_frag_y) < 0) ||
                      (int'(i_frag_x) >= FB_WIDTH) || (int'(i_frag_y) >= FB_HEIGHT);
    assign w_addr   = r_base
                    + ADDR_WIDTH'($unsigned(i_frag_y)) * ADDR_WIDTH'(FB_WIDTH)
                    + ADDR_WIDTH'($unsigned(i_frag_x));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_accept && !w_clip;
            if (w_accept && !w_clip) r_s1_addr <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_clip_count <= '0;
        else if (w_start)            r_clip_count <= '0;
        else if (w_accept && w_clip) r_clip_count <= sat_inc16(r_clip_count);
    end

    // ---------------- stage 2: write buffer ----------------
    assign w_fifo_din = '{addr: r_s1_addr, data: r_color};
    assign w_pop      = !w_fifo_empty && i_mem_wr_ready;
    assign w_drop     = r_s1_valid && w_fifo_full && !w_pop;
    assign w_drained  = !r_s1_valid && w_fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_overflow <= 1'b0;
        else if (w_start) r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;
    end

    frag_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s1_valid),
        .i_din   (w_fifo_din),
        .i_pop   (i_mem_wr_ready),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_mem_wr_valid = !w_fifo_empty;
    assign o_mem_wr_addr  = w_fifo_dout.addr;
    assign o_mem_wr_data  = w_fifo_dout.data;
    assign o_busy         = (r_state != IDLE);
    assign o_overflow     = r_overflow;
    assign o_clip_count   = r_clip_count;

endmodule

// File: tb/tb_fragment_writer.sv
// Scoreboard bench for fragment_writer: in-bounds fragments queue their expected
// write, and every accepted memory write is popped and compared in order.
module tb_fragment_writer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic [15:0]        i_color = '0;
    logic [19:0]        i_fb_base = '0;
    logic               i_frag_valid = 1'b0;
    logic signed [9:0]  i_frag_x = '0;
    logic signed [9:0]  i_frag_y = '0;
    logic               i_raster_done = 1'b1;
    logic               i_mem_wr_ready = 1'b1;
    logic               o_mem_wr_valid;
    logic [19:0]        o_mem_wr_addr;
    logic [15:0]        o_mem_wr_data;
    logic               o_busy;
    logic               o_done;
    logic               o_overflow;
    logic [15:0]        o_clip_count;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [35:0] sb [$];
    logic [19:0] cur_base = '0;
    logic [15:0] cur_color = '0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_word = '0;

    fragment_writer #(
        .CORD_WIDTH (10),
        .ADDR_WIDTH (20),
        .COLOR_WIDTH(16),
        .FB_WIDTH   (640),
        .FB_HEIGHT  (480),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_color       (i_color),
        .i_fb_base     (i_fb_base),
        .i_frag_valid  (i_frag_valid),
        .i_frag_x      (i_frag_x),
        .i_frag_y      (i_frag_y),
        .i_raster_done (i_raster_done),
        .o_mem_wr_valid(o_mem_wr_valid),
        .i_mem_wr_ready(i_mem_wr_ready),
        .o_mem_wr_addr (o_mem_wr_addr),
        .o_mem_wr_data (o_mem_wr_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_clip_count  (o_clip_count)
    );

    always #5 clk = ~clk;

    // One clock: sample on the falling edge, pop the scoreboard on each write,
    // check head stability under stall, then return just after the rising edge.
    task automatic tick();
        logic [35:0] got;
        logic [35:0] want;
        @(negedge clk);
        got = {o_mem_wr_addr, o_mem_wr_data};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (o_mem_wr_valid !== 1'b1 || got !== prev_word) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b word=%h, expected valid=1 word=%h",
                             o_mem_wr_valid, got, prev_word);
                end
            end
            if (o_mem_wr_valid && i_mem_wr_ready) begin
                wr_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                             o_mem_wr_addr, o_mem_wr_data);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                                 got[35:16], got[15:0], want[35:16], want[15:0]);
                    end
                end
            end
            if (o_done === 1'b1) done_count++;
            prev_stall = o_mem_wr_valid && !i_mem_wr_ready;
            prev_word  = got;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_tri(input logic [19:0] base, input logic [15:0] color);
        cur_base  = base;
        cur_color = color;
        i_fb_base = base;
        i_color   = color;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic frag(input int x, input int y, input bit keep);
        logic signed [9:0] xs;
        logic signed [9:0] ys;
        int                a;
        xs = x[9:0];
        ys = y[9:0];
        i_frag_valid = 1'b1;
        i_frag_x     = xs;
        i_frag_y     = ys;
        if (keep && xs >= 0 && ys >= 0 && xs < 640 && ys < 480) begin
            a = int'(cur_base) + int'(ys) * 640 + int'(xs);
            sb.push_back({a[19:0], cur_color});
        end
        tick();
        i_frag_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_count;
        for (int i = 0; i < budget && done_count == d0; i++) tick();
        checks++;
        if (done_count == d0) begin
            errors++;
            $display("FAIL done_timeout_%s: got no o_done in %0d cycles, expected a pulse", tag, budget);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d writes outstanding, expected 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_mem_wr_valid, o_busy, o_done, o_overflow, o_clip_count} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b done=%b ovf=%b clip=%0d, expected all 0",
                     o_mem_wr_valid, o_busy, o_done, o_overflow, o_clip_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        i_mem_wr_ready = 1'b1;
        i_raster_done  = 1'b1;
        start_tri(20'h01000, 16'hF800);
        i_raster_done = 1'b0;
        n = wr_count;
        frag(3, 2, 1'b1);
        checks++;
        if (o_mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_n1: got valid=%b, expected 0", o_mem_wr_valid);
        end
        tick();
        checks++;
        if (o_mem_wr_valid !== 1'b1 || o_mem_wr_addr !== 20'h01503 || o_mem_wr_data !== 16'hF800) begin
            errors++;
            $display("FAIL latency_n2: got valid=%b addr=%h data=%h, expected 1 01503 f800",
                     o_mem_wr_valid, o_mem_wr_addr, o_mem_wr_data);
        end
        i_raster_done = 1'b1;
        wait_done(20, "single");
        checks++;
        if (wr_count - n != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got writes=%0d busy=%b, expected 1 0", wr_count - n, o_busy);
        end
    endtask

    task automatic test_clip();
        int n;
        start_tri(20'h02000, 16'h07E0);
        i_raster_done = 1'b0;
        n = wr_count;
        frag(-1, 0, 1'b1);
        frag(640, 5, 1'b1);
        frag(0, 480, 1'b1);
        frag(5, 5, 1'b1);
        i_raster_done = 1'b1;
        wait_done(20, "clip");
        checks++;
        if (wr_count - n != 1 || o_clip_count !== 16'd3) begin
            errors++;
            $display("FAIL clip_count: got writes=%0d clip=%0d, expected 1 3", wr_count - n, o_clip_count);
        end
    endtask

    task automatic test_backpressure();
        int n;
        i_mem_wr_ready = 1'b0;
        start_tri(20'h10000, 16'h1234);
        i_raster_done = 1'b0;
        n = wr_count;
        for (int i = 0; i < 16; i++) frag(i * 7, 100 + i, 1'b1);
        repeat (4) tick();
        checks++;
        if (o_mem_wr_valid !== 1'b1 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_stalled: got valid=%b ovf=%b, expected 1 0", o_mem_wr_valid, o_overflow);
        end
        i_mem_wr_ready = 1'b1;
        i_raster_done  = 1'b1;
        wait_done(60, "bp");
        checks++;
        if (wr_count - n != 16 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: got writes=%0d ovf=%b, expected 16 0", wr_count - n, o_overflow);
        end
    endtask

    task automatic test_overflow();
        int n;
        i_mem_wr_ready = 1'b0;
        start_tri(20'h20000, 16'hABCD);
        i_raster_done = 1'b0;
        n = wr_count;
        for (int i = 0; i < 18; i++) frag(i, 479, i < 16);
        repeat (3) tick();
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b, expected 1", o_overflow);
        end
        i_mem_wr_ready = 1'b1;
        i_raster_done  = 1'b1;
        wait_done(60, "ovf");
        checks++;
        if (wr_count - n != 16 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count: got writes=%0d ovf=%b, expected 16 1", wr_count - n, o_overflow);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_count;
        start_tri(20'h30000, 16'h0F0F);
        checks++;
        if (o_overflow !== 1'b0 || o_clip_count !== 16'd0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_clears: got ovf=%b clip=%0d busy=%b, expected 0 0 1",
                     o_overflow, o_clip_count, o_busy);
        end
        i_raster_done = 1'b0;
        frag(1, 1, 1'b1);
        frag(2, 1, 1'b1);
        i_raster_done = 1'b1;
        wait_done(20, "b2b_a");
        start_tri(20'h30100, 16'hF0F0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: got busy=%b, expected 1", o_busy);
        end
        i_raster_done = 1'b0;
        frag(0, 0, 1'b1);
        i_raster_done = 1'b1;
        wait_done(20, "b2b_b");
        checks++;
        if (done_count - d0 != 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses, expected 2", done_count - d0);
        end
    endtask

    task automatic test_done_arming();
        int d0;
        i_mem_wr_ready = 1'b1;
        i_raster_done  = 1'b1;
        d0 = done_count;
        start_tri(20'h40000, 16'h5555);
        tick();
        i_raster_done = 1'b0;
        frag(4, 4, 1'b1);
        tick();
        tick();
        checks++;
        if (done_count != d0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_early: got pulses=%0d busy=%b, expected 0 1", done_count - d0, o_busy);
        end
        i_raster_done = 1'b1;
        wait_done(20, "arm");
        repeat (5) tick();
        checks++;
        if (done_count - d0 != 1) begin
            errors++;
            $display("FAIL arm_once: got %0d pulses, expected 1", done_count - d0);
        end
    endtask

    task automatic test_reset_mid_drain();
        int n;
        i_mem_wr_ready = 1'b0;
        start_tri(20'h50000, 16'h3333);
        i_raster_done = 1'b0;
        for (int i = 0; i < 5; i++) frag(10 + i, 20, 1'b1);
        i_raster_done = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_mem_wr_valid !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got valid=%b busy=%b, expected 1 1", o_mem_wr_valid, o_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_mem_wr_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b busy=%b, expected 0 0", o_mem_wr_valid, o_busy);
        end
        sb.delete();
        n = wr_count;
        tick();
        tick();
        rst_n = 1'b1;
        i_mem_wr_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (wr_count != n || o_busy !== 1'b0 || o_mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_writes: got writes=%0d busy=%b valid=%b, expected 0 0 0",
                     wr_count - n, o_busy, o_mem_wr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_done_arming();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
